// File: rtl/e10_mon_pkg.sv
// Shared types and constants for the e10 output monitor.
package e10_mon_pkg;

    // Monitor operating states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StAlarm = 2'd2
    } mon_state_e;

    localparam int unsigned NUM_CODES = 18;

    // code_idx value reported for a vector outside the legal table.
    localparam logic [4:0] ILLEGAL_IDX = 5'd31;

    // Bit positions within the cause vector.
    localparam int unsigned CAUSE_ILLEGAL = 0;
    localparam int unsigned CAUSE_STALL   = 1;
    localparam int unsigned CAUSE_TOGGLE  = 2;

    // Legal controller output vectors; bit n-1 carries y<n>.
    localparam logic [12:0] LEGAL_CODES [NUM_CODES] = '{
        13'h0000,  // 0:  {}
        13'h1100,  // 1:  y9 y13
        13'h0003,  // 2:  y1 y2
        13'h0110,  // 3:  y5 y9
        13'h0017,  // 4:  y1 y2 y3 y5
        13'h0440,  // 5:  y7 y11
        13'h0170,  // 6:  y5 y6 y7 y9
        13'h0140,  // 7:  y7 y9
        13'h0001,  // 8:  y1
        13'h000D,  // 9:  y1 y3 y4
        13'h0002,  // 10: y2
        13'h1010,  // 11: y5 y13
        13'h1000,  // 12: y13
        13'h1030,  // 13: y5 y6 y13
        13'h0A00,  // 14: y10 y12
        13'h0088,  // 15: y4 y8
        13'h1440,  // 16: y7 y11 y13
        13'h0200   // 17: y10
    };

endpackage

// File: rtl/e10_code_lookup.sv
// Combinational match of a controller output vector against the legal-code table.
module e10_code_lookup
    import e10_mon_pkg::*;
(
    input  logic [12:0] y_i,
    output logic        hit_o,
    output logic [4:0]  idx_o
);

    // Table entries are distinct, so at most one comparison can match.
    always_comb begin
        hit_o = 1'b0;
        idx_o = ILLEGAL_IDX;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (y_i == LEGAL_CODES[i]) begin
                hit_o = 1'b1;
                idx_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/e10_out_monitor.sv
// Runtime monitor for the e10 controller outputs: legal-code, stall and toggle
// checks plus a per-window MISR signature.
module e10_out_monitor
    import e10_mon_pkg::*;
#(
    parameter int unsigned WIN_LEN   = 64,
    parameter int unsigned STALL_MAX = 16,
    parameter int unsigned TOG_MAX   = 48,
    parameter logic [15:0] SIG_SEED  = 16'hFFFF,
    parameter logic [15:0] SIG_POLY  = 16'h1021
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [12:0] y_in,
    output logic        alarm,
    output logic [2:0]  cause,
    output logic [4:0]  code_idx,
    output logic [15:0] signature,
    output logic        sig_valid,
    output logic        win_done
);

    localparam int unsigned CntW = $clog2(WIN_LEN + 1);
    localparam int unsigned RunW = $clog2(STALL_MAX + 1);

    localparam logic [CntW-1:0] WinLast = CntW'(WIN_LEN - 1);
    localparam logic [RunW-1:0] RunMax  = RunW'(STALL_MAX);

    mon_state_e      state_q;
    logic [15:0]     misr_q;
    logic [CntW-1:0] win_q;
    logic [CntW-1:0] tog_q;
    logic [RunW-1:0] run_q;
    logic [12:0]     prev_q;
    logic            alarm_q;
    logic [2:0]      cause_q;
    logic [4:0]      code_idx_q;
    logic [15:0]     signature_q;
    logic            sig_valid_q;
    logic            win_done_q;

    logic            hit;
    logic [4:0]      idx;
    logic [15:0]     misr_upd;
    logic [CntW-1:0] tog_upd;
    logic [RunW-1:0] run_upd;
    logic            changed;
    logic            win_last;
    logic [2:0]      det_cause;

    e10_code_lookup u_lookup (
        .y_i   (y_in),
        .hit_o (hit),
        .idx_o (idx)
    );

    // Per-sample updates and detection, evaluated as if this cycle is a RUN sample.
    always_comb begin
        misr_upd = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? SIG_POLY : 16'h0000) ^ {3'b000, y_in};
        changed  = (y_in != prev_q);
        win_last = (win_q == WinLast);
        if (changed) begin
            run_upd = RunW'(1);
            tog_upd = (tog_q == '1) ? tog_q : tog_q + 1'b1;
        end else begin
            run_upd = (run_q >= RunMax) ? RunMax : run_q + 1'b1;
            tog_upd = tog_q;
        end
        det_cause                = '0;
        det_cause[CAUSE_ILLEGAL] = !hit;
        det_cause[CAUSE_STALL]   = (run_upd == RunMax) && (y_in != 13'h0000);
        det_cause[CAUSE_TOGGLE]  = 32'(tog_upd) > TOG_MAX;
    end

    // Monitor FSM with all counters and registered outputs; clr outranks every event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            misr_q      <= SIG_SEED;
            win_q       <= '0;
            tog_q       <= '0;
            run_q       <= '0;
            prev_q      <= '0;
            alarm_q     <= 1'b0;
            cause_q     <= '0;
            code_idx_q  <= '0;
            signature_q <= '0;
            sig_valid_q <= 1'b0;
            win_done_q  <= 1'b0;
        end else if (clr) begin
            state_q     <= StIdle;
            misr_q      <= SIG_SEED;
            win_q       <= '0;
            tog_q       <= '0;
            run_q       <= '0;
            prev_q      <= '0;
            alarm_q     <= 1'b0;
            cause_q     <= '0;
            signature_q <= '0;
            sig_valid_q <= 1'b0;
            win_done_q  <= 1'b0;
        end else begin
            win_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q <= StRun;
                        misr_q  <= SIG_SEED;
                        win_q   <= '0;
                        tog_q   <= '0;
                        run_q   <= '0;
                    end
                end
                StRun: begin
                    if (!en) begin
                        // Partial window is dropped; counters restart on next entry.
                        state_q <= StIdle;
                    end else begin
                        code_idx_q <= idx;
                        prev_q     <= y_in;
                        run_q      <= run_upd;
                        if (win_last) begin
                            signature_q <= misr_upd;
                            sig_valid_q <= 1'b1;
                            win_done_q  <= 1'b1;
                            misr_q      <= SIG_SEED;
                            win_q       <= '0;
                            tog_q       <= '0;
                        end else begin
                            misr_q <= misr_upd;
                            win_q  <= win_q + 1'b1;
                            tog_q  <= tog_upd;
                        end
                        if (|det_cause) begin
                            alarm_q <= 1'b1;
                            cause_q <= cause_q | det_cause;
                            state_q <= StAlarm;
                        end
                    end
                end
                StAlarm: begin
                    // Everything frozen until clr.
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alarm     = alarm_q;
    assign cause     = cause_q;
    assign code_idx  = code_idx_q;
    assign signature = signature_q;
    assign sig_valid = sig_valid_q;
    assign win_done  = win_done_q;

endmodule

// File: tb/tb_e10_out_monitor.sv
// Self-checking bench for e10_out_monitor.
module tb_e10_out_monitor;

    localparam int unsigned WIN_LEN = 64;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [12:0] y_in;
    logic        alarm;
    logic [2:0]  cause;
    logic [4:0]  code_idx;
    logic [15:0] signature;
    logic        sig_valid;
    logic        win_done;

    e10_out_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .y_in      (y_in),
        .alarm     (alarm),
        .cause     (cause),
        .code_idx  (code_idx),
        .signature (signature),
        .sig_valid (sig_valid),
        .win_done  (win_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] y;
        logic [4:0]  idx;
        logic        alarm;
        logic [2:0]  cause;
    } vec_t;

    typedef struct {
        logic [4:0] idx;
        logic       alarm;
        logic [2:0] cause;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    vec_t        tbl [20];
    exp_t        exp_q [$];
    logic [15:0] sig_q [$];
    logic [15:0] mdl_misr;
    int          mdl_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [12:0] y);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {3'b000, y};
    endfunction

    // Drive one cycle, sample 1 time unit after the edge, score any finished window.
    task automatic tick(input logic e, input logic c, input logic [12:0] y);
        en   = e;
        clr  = c;
        y_in = y;
        @(posedge clk);
        #1;
        if (win_done === 1'b1) begin
            chk("win_done_expected", 32'(sig_q.size() != 0), 32'd1);
            if (sig_q.size() != 0) chk("signature", 32'(signature), 32'(sig_q.pop_front()));
        end
    endtask

    // One RUN sample; the window model pushes the golden signature on the last sample.
    task automatic sample(input logic [12:0] y);
        mdl_misr = misr_step(mdl_misr, y);
        mdl_cnt++;
        if (mdl_cnt == WIN_LEN) begin
            sig_q.push_back(mdl_misr);
            mdl_misr = 16'hFFFF;
            mdl_cnt  = 0;
        end
        tick(1'b1, 1'b0, y);
    endtask

    task automatic enter_run();
        tick(1'b1, 1'b0, 13'h0000);
        mdl_misr = 16'hFFFF;
        mdl_cnt  = 0;
    endtask

    task automatic do_clr();
        tick(1'b0, 1'b1, 13'h0000);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alarm"}, 32'(alarm), 32'd0);
        chk({tag, "_cause"}, 32'(cause), 32'd0);
        chk({tag, "_code_idx"}, 32'(code_idx), 32'd0);
        chk({tag, "_signature"}, 32'(signature), 32'd0);
        chk({tag, "_sig_valid"}, 32'(sig_valid), 32'd0);
        chk({tag, "_win_done"}, 32'(win_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gold;
        int          early;
        exp_t        e;

        tbl[0]  = '{13'h0000, 5'd0,  1'b0, 3'b000};
        tbl[1]  = '{13'h1100, 5'd1,  1'b0, 3'b000};
        tbl[2]  = '{13'h0003, 5'd2,  1'b0, 3'b000};
        tbl[3]  = '{13'h0110, 5'd3,  1'b0, 3'b000};
        tbl[4]  = '{13'h0017, 5'd4,  1'b0, 3'b000};
        tbl[5]  = '{13'h0440, 5'd5,  1'b0, 3'b000};
        tbl[6]  = '{13'h0170, 5'd6,  1'b0, 3'b000};
        tbl[7]  = '{13'h0140, 5'd7,  1'b0, 3'b000};
        tbl[8]  = '{13'h0001, 5'd8,  1'b0, 3'b000};
        tbl[9]  = '{13'h000D, 5'd9,  1'b0, 3'b000};
        tbl[10] = '{13'h0002, 5'd10, 1'b0, 3'b000};
        tbl[11] = '{13'h1010, 5'd11, 1'b0, 3'b000};
        tbl[12] = '{13'h1000, 5'd12, 1'b0, 3'b000};
        tbl[13] = '{13'h1030, 5'd13, 1'b0, 3'b000};
        tbl[14] = '{13'h0A00, 5'd14, 1'b0, 3'b000};
        tbl[15] = '{13'h0088, 5'd15, 1'b0, 3'b000};
        tbl[16] = '{13'h1440, 5'd16, 1'b0, 3'b000};
        tbl[17] = '{13'h0200, 5'd17, 1'b0, 3'b000};
        tbl[18] = '{13'h0007, 5'd31, 1'b1, 3'b001};
        tbl[19] = '{13'h0001, 5'd31, 1'b1, 3'b001};  // frozen in alarm

        rst  = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        y_in = 13'h0000;
        mdl_misr = 16'hFFFF;
        mdl_cnt  = 0;
        #22;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // One window of zeros.
        gold = 16'hFFFF;
        for (int i = 0; i < 64; i++) gold = misr_step(gold, 13'h0000);
        enter_run();
        chk("enter_win_done", 32'(win_done), 32'd0);
        for (int i = 0; i < 64; i++) begin
            sample(13'h0000);
            chk("zero_win_done", 32'(win_done), 32'(i == 63));
        end
        chk("zero_sig_golden", 32'(signature), 32'(gold));
        chk("zero_sig_valid", 32'(sig_valid), 32'd1);
        chk("zero_alarm", 32'(alarm), 32'd0);
        sample(13'h0000);
        chk("pulse_one_cycle", 32'(win_done), 32'd0);

        // Illegal code and freeze.
        sample(13'h0007);
        chk("illegal_idx", 32'(code_idx), 32'd31);
        chk("illegal_alarm", 32'(alarm), 32'd1);
        chk("illegal_cause", 32'(cause), 32'd1);
        for (int i = 0; i < 70; i++) tick(1'b1, 1'b0, 13'h0000);
        chk("frozen_sig", 32'(signature), 32'(gold));
        chk("frozen_idx", 32'(code_idx), 32'd31);
        chk("frozen_alarm", 32'(alarm), 32'd1);

        // clr, then IDLE does not sample, then clr beats a detection.
        do_clr();
        chk("clr_alarm", 32'(alarm), 32'd0);
        chk("clr_cause", 32'(cause), 32'd0);
        chk("clr_sig_valid", 32'(sig_valid), 32'd0);
        chk("clr_signature", 32'(signature), 32'd0);
        tick(1'b1, 1'b0, 13'h0007);
        chk("idle_no_sample", 32'(alarm), 32'd0);
        tick(1'b1, 1'b1, 13'h0007);
        chk("clr_vs_illegal_alarm", 32'(alarm), 32'd0);
        chk("clr_vs_illegal_cause", 32'(cause), 32'd0);

        // Table-driven code lookup via scoreboard.
        enter_run();
        chk("after_clr_run_alarm", 32'(alarm), 32'd0);
        foreach (tbl[k]) begin
            exp_q.push_back('{tbl[k].idx, tbl[k].alarm, tbl[k].cause});
            tick(1'b1, 1'b0, tbl[k].y);
            e = exp_q.pop_front();
            chk($sformatf("tbl%0d_idx", k), 32'(code_idx), 32'(e.idx));
            chk($sformatf("tbl%0d_alarm", k), 32'(alarm), 32'(e.alarm));
            chk($sformatf("tbl%0d_cause", k), 32'(cause), 32'(e.cause));
        end

        // Stall: 16 identical non-zero samples.
        do_clr();
        enter_run();
        early = 0;
        for (int i = 0; i < 16; i++) begin
            sample(13'h0140);
            if (i < 15 && alarm !== 1'b0) early++;
        end
        chk("stall_early", 32'(early), 32'd0);
        chk("stall_alarm", 32'(alarm), 32'd1);
        chk("stall_cause", 32'(cause), 32'd2);
        chk("stall_idx", 32'(code_idx), 32'd7);

        // Zero held 100 samples: no stall.
        do_clr();
        enter_run();
        early = 0;
        for (int i = 0; i < 100; i++) begin
            sample(13'h0000);
            if (alarm !== 1'b0) early++;
        end
        chk("zero_hold_alarms", 32'(early), 32'd0);
        chk("zero_hold_sig_valid", 32'(sig_valid), 32'd1);

        // Window completion and detection on the same sample.
        do_clr();
        enter_run();
        for (int i = 0; i < 63; i++) sample(13'h0000);
        gold = mdl_misr;
        gold = misr_step(gold, 13'h0007);
        sample(13'h0007);
        chk("both_win_done", 32'(win_done), 32'd1);
        chk("both_sig", 32'(signature), 32'(gold));
        chk("both_alarm", 32'(alarm), 32'd1);
        chk("both_cause", 32'(cause), 32'd1);
        tick(1'b1, 1'b0, 13'h0000);
        chk("both_pulse_end", 32'(win_done), 32'd0);

        // Toggle overflow on the 49th change.
        do_clr();
        enter_run();
        early = 0;
        for (int i = 1; i <= 49; i++) begin
            sample((i % 2 == 1) ? 13'h0001 : 13'h0002);
            if (i < 49 && alarm !== 1'b0) early++;
        end
        chk("tog_early", 32'(early), 32'd0);
        chk("tog_alarm", 32'(alarm), 32'd1);
        chk("tog_cause", 32'(cause), 32'd4);
        chk("tog_idx", 32'(code_idx), 32'd8);

        // Asynchronous reset mid-window.
        do_clr();
        enter_run();
        for (int i = 0; i < 64; i++) sample(13'h0000);
        for (int i = 0; i < 30; i++) sample((i % 2 == 0) ? 13'h0003 : 13'h1100);
        chk("pre_rst_idx", 32'(code_idx), 32'd1);
        chk("pre_rst_sig_valid", 32'(sig_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        #2;
        rst = 1'b1;
        enter_run();
        gold = 16'hFFFF;
        for (int i = 0; i < 64; i++) gold = misr_step(gold, 13'h0000);
        for (int i = 0; i < 64; i++) begin
            sample(13'h0000);
            chk("post_rst_win_done", 32'(win_done), 32'(i == 63));
        end
        chk("post_rst_sig", 32'(signature), 32'(gold));

        chk("sig_queue_drained", 32'(sig_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/e10_out_monitor.md
Name: e10_out_monitor

Overview:
- Runtime monitor placed directly downstream of the e10 controller. It samples the controller's 13-bit output vector y1..y13 on every rising clk edge.
- The controller updates on the falling edge, so its combinational outputs are stable when sampled.
- It checks each sampled vector against the legal output-code set and detects stuck codes and excessive toggling.
- It compresses each observation window into a MISR signature for off-line comparison against a golden run. This is our trojan-activity detector for this FSM family.

Parameters:
- WIN_LEN, 64, sampled cycles per signature window (>=2).
- STALL_MAX, 16, consecutive identical non-zero codes that trigger a stall alarm (>=2).
- TOG_MAX, 48, vector changes per window above which a toggle alarm fires.
- SIG_SEED, 16'hFFFF, MISR seed value at reset, clear and window start.
- SIG_POLY, 16'h1021, MISR feedback polynomial.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; y_in is observed only when en=1.
- clr  in  1  synchronous clear of the alarm, counters and MISR.
- y_in  in  13  controller outputs; bit0=y1 … bit12=y13.
- alarm  out  1  sticky alarm.
- cause  out  3  sticky cause bits: [0] illegal code, [1] stall, [2] toggle overflow.
- code_idx  out  5  index of the last sampled code in the legal table; 31 if illegal.
- signature  out  16  last completed-window MISR value.
- sig_valid  out  1  signature holds at least one completed window.
- win_done  out  1  one-cycle pulse when a window completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - alarm=0, cause=0, code_idx=0, signature=0, sig_valid=0, win_done=0.
  - MISR=SIG_SEED; win_cnt, tog_cnt, run_len=0; prev=0; state=IDLE.
- Legal code table, 18 entries, indices 0..17, with bits named by y number:
  - 0: {}
  - 1: {9,13}
  - 2: {1,2}
  - 3: {5,9}
  - 4: {1,2,3,5}
  - 5: {7,11}
  - 6: {5,6,7,9}
  - 7: {7,9}
  - 8: {1}
  - 9: {1,3,4}
  - 10: {2}
  - 11: {5,13}
  - 12: {13}
  - 13: {5,6,13}
  - 14: {10,12}
  - 15: {4,8}
  - 16: {7,11,13}
  - 17: {10}
- States: IDLE, RUN, ALARM.
  - IDLE: no sampling. en=1 moves to RUN; win_cnt, tog_cnt, run_len are zeroed and MISR=SIG_SEED on entry.
  - RUN, with en=1 each cycle:
    - code_idx is updated.
    - MISR <= (MISR<<1) ^ (MISR[15] ? SIG_POLY : 0) ^ {3'b0,y_in}.
    - If y_in != prev, tog_cnt++ and run_len=1; otherwise run_len++, saturating at STALL_MAX.
    - prev <= y_in.
  - RUN, with en=0: return to IDLE. signature and sig_valid are held; the partial window is discarded.
  - Detection on a sample; all detected causes set in the same cycle:
    - illegal: y_in is not in the table.
    - stall: run_len reaches STALL_MAX with y_in != 0.
    - toggle: tog_cnt exceeds TOG_MAX.
    - On detection, alarm=1 and cause bits OR in on the next edge (latency 1), and the state moves to ALARM.
  - Window completion: the sample with win_cnt=WIN_LEN-1 completes the window.
    - Next cycle: signature = updated MISR, sig_valid=1, win_done=1 for exactly one cycle.
    - MISR=SIG_SEED, win_cnt=0, tog_cnt=0.
    - run_len is not reset across windows.
  - ALARM: MISR, counters and code_idx are frozen; alarm and cause are held until clr.
- clr=1 in any state, next edge:
  - alarm=0, cause=0, sig_valid=0, signature=0; MISR seeded; counters zeroed; prev=0; state=IDLE.
  - clr has priority over detection and window completion in the same cycle.
- A window completion and a detection on the same sample: both take effect. signature updates, win_done pulses, and the state goes to ALARM.
- Counter widths: win_cnt and tog_cnt are wide enough for WIN_LEN; tog_cnt saturates.

Decomposition:
- Package e10_mon_pkg holds:
  - the state enum;
  - the 18-entry legal-code constant array;
  - cause bit indices;
  - the ILLEGAL_IDX=31 constant.
- One sub-module, e10_code_lookup: combinational y_in → {hit, idx[4:0]} using the package table.

Test Plan:
- Reset, then en=1 with y_in=13'h0 for 64 cycles → win_done pulses once on cycle 65; sig_valid=1; alarm=0; signature equals the golden model for 64 zero inputs seeded 16'hFFFF.
- RUN, then y_in=13'h0007 (y1,y2,y3) → code_idx=31, alarm=1 and cause=3'b001 one cycle later; further samples leave signature unchanged.
- y_in={y7,y9}=13'h0140 held 16 cycles → alarm with cause=3'b010 after the 16th sample. Holding 13'h0 for 100 cycles gives no alarm.
- Alternate 13'h0001 and 13'h0002 every cycle, TOG_MAX=48 → cause=3'b100 on the 49th change, before the 64-cycle window ends.
- Alarm raised, then clr=1 for one cycle → alarm=0, cause=0, sig_valid=0, state IDLE. clr asserted in the same cycle as an illegal code → no alarm.
- rst pulsed low mid-window (win_cnt=30), asynchronously between edges → all outputs reach reset values immediately. After release with en=1, the first win_done occurs 64 samples later.
